// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit and its controller.
// Also holds the fault, byte-lane and store-replication helpers.
`timescale 1ns/1ps
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int TIMEOUT_DEF = 15;

  localparam logic [6:0] LOAD  = 7'd3;
  localparam logic [6:0] STORE = 7'd35;

  // Only meaningful when at least one strobe is high.
  function automatic logic access_fault(logic rd, logic wr, logic [2:0] f3, logic [1:0] off);
    logic f3_ok;
    if (wr) f3_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else    f3_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                    (f3 == F3_BU) || (f3 == F3_HU);
    return (rd & wr) | ~f3_ok |
           ((f3[1:0] == 2'b01) & off[0]) |
           ((f3[1:0] == 2'b10) & (off != 2'b00));
  endfunction

  function automatic logic [3:0] lane_mask(logic [2:0] f3, logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(logic [2:0] f3, logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: shifts the addressed bytes down to bit 0 and
// sign- or zero-extends according to funct3.
`timescale 1ns/1ps
module load_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word_i,
  input  logic [1:0]      offset_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = word_i >> {offset_i, 3'b000};
    rdata_o = shifted;
    case (funct3_i)
      F3_B:    rdata_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_H:    rdata_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_BU:   rdata_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_HU:   rdata_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: rdata_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one valid/ready data-memory transaction per memread/memwrite
// strobe, stalling the core until DONE. Faults finish without a bus access.
//
//   state   | meaning
//   IDLE    | waiting for a strobe; stall follows the strobe combinationally
//   REQ     | mem_valid high, request fields held until mem_ready
//   RESP    | load accepted, waiting for mem_rvalid
//   DONE    | one cycle: stall low, rdata/err presented to writeback
`timescale 1ns/1ps
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            memread,
  input  logic            memwrite,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata,
  output logic            stall,
  output logic            err,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  lsu_state_e      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [2:0]      f3_q, f3_d;
  logic            we_q, we_d;
  logic [3:0]      be_q, be_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [XLEN-1:0] load_word;
  logic            req;
  logic            fault;
  logic            timeout;

  load_align #(.XLEN(XLEN)) u_align (
    .word_i   (mem_rdata),
    .offset_i (addr_q[1:0]),
    .funct3_i (f3_q),
    .rdata_o  (load_word)
  );

  assign req     = memread | memwrite;
  assign fault   = access_fault(memread, memwrite, funct3, addr[1:0]);
  // Terminal count is the TIMEOUT-th cycle spent in REQ+RESP.
  assign timeout = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    f3_d    = f3_q;
    we_d    = we_q;
    be_d    = be_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (fault) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = ST_REQ;
            addr_d  = addr;
            f3_d    = funct3;
            we_d    = memwrite;
            be_d    = lane_mask(funct3, addr[1:0]);
            wdata_d = store_lanes(funct3, wdata);
            cnt_d   = '0;
          end
        end
      end
      ST_REQ: begin
        if (mem_ready) begin
          state_d = we_q ? ST_DONE : ST_RESP;
          cnt_d   = cnt_q + CW'(1);
          if (we_q) rdata_d = '0;
        end else if (timeout) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RESP: begin
        if (mem_rvalid) begin
          state_d = ST_DONE;
          rdata_d = load_word;
        end else if (timeout) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      be_q    <= be_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_valid = (state_q == ST_REQ);
  assign mem_we    = we_q;
  assign mem_addr  = {addr_q[XLEN-1:2], 2'b00};
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign stall     = ((state_q == ST_IDLE) & req) |
                     (state_q == ST_REQ) | (state_q == ST_RESP);

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized transactions
// compared against a byte-arithmetic reference model.
`timescale 1ns/1ps
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        memread = 1'b0, memwrite = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        stall, err;
  logic        mem_valid, mem_we;
  logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [3:0]  mem_be;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu #(.XLEN(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .memread(memread), .memwrite(memwrite),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .err(err), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  // ---------------- reference model ----------------
  function automatic int m_size(int f3);
    return 1 << (f3 % 4);
  endfunction

  function automatic logic [31:0] m_mask(int sz);
    if (sz >= 4) return 32'hFFFF_FFFF;
    return (32'h1 << (8 * sz)) - 32'h1;
  endfunction

  function automatic bit m_fault(bit rd, bit wr, int f3, logic [31:0] a);
    if (rd && wr) return 1'b1;
    if (wr && f3 > 2) return 1'b1;
    if (rd && !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) return 1'b1;
    return (a % m_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(int f3, logic [31:0] a);
    int sz;
    sz = m_size(f3);
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(int f3, logic [31:0] wd);
    int sz;
    logic [31:0] r;
    sz = m_size(f3);
    r = '0;
    for (int i = 0; i < 4 / sz; i++) r |= (wd & m_mask(sz)) << (8 * sz * i);
    return r;
  endfunction

  function automatic logic [31:0] m_load(int f3, logic [31:0] a, logic [31:0] w);
    int sz;
    logic [31:0] v;
    sz = m_size(f3);
    v = (w >> (8 * (a % 4))) & m_mask(sz);
    if (f3 < 4 && sz < 4 && v[8*sz-1]) v |= ~m_mask(sz);
    return v;
  endfunction

  // ---------------- transaction driver / bus responder ----------------
  task automatic run_txn(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] word, input int rdy_dly,
                         input int rv_dly, input bit no_rv,
                         output int stalls, output int valids, output bit stable,
                         output logic [31:0] o_addr, output logic [31:0] o_wdata,
                         output logic [3:0] o_be, output bit o_we,
                         output logic [31:0] o_rdata, output bit o_err,
                         output bit err_early, output bit timed_out);
    bit hs;
    bit done;
    int rcnt;
    stalls = 0; valids = 0; stable = 1'b1; o_addr = '0; o_wdata = '0;
    o_be = '0; o_we = 1'b0; o_rdata = '0; o_err = 1'b0; err_early = 1'b0;
    hs = 1'b0; done = 1'b0; rcnt = 0;
    @(posedge clk); #1;
    memread = rd; memwrite = wr; funct3 = f3; addr = a; wdata = wd;
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(negedge clk);
      if (stall) begin
        stalls++;
        if (err) err_early = 1'b1;
        mem_ready = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = $urandom;
        if (mem_valid) begin
          if (valids == 0) begin
            o_addr = mem_addr; o_wdata = mem_wdata; o_be = mem_be; o_we = mem_we;
          end else if (mem_addr !== o_addr || mem_wdata !== o_wdata ||
                       mem_be !== o_be || mem_we !== o_we) begin
            stable = 1'b0;
          end
          if (valids == rdy_dly) begin
            mem_ready = 1'b1;
            hs = 1'b1;
          end
          // stray responses during REQ must be ignored
          mem_rvalid = 1'($urandom_range(0, 1));
          valids++;
        end else if (hs && rd && !no_rv) begin
          if (rcnt == rv_dly) begin
            mem_rvalid = 1'b1;
            mem_rdata = word;
          end
          rcnt++;
        end
      end else begin
        done = 1'b1;
        o_rdata = rdata;
        o_err = err;
      end
    end
    timed_out = !done;
    @(posedge clk); #1;
    memread = 1'b0; memwrite = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({mem_valid, mem_we, err, stall} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b exp 0000", {mem_valid, mem_we, err, stall});
    end
    checks++;
    if (mem_be !== 4'h0 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_bus: be %h addr %h exp 0/0", mem_be, mem_addr);
    end
    checks++;
    if (mem_wdata !== 32'h0 || rdata !== 32'h0) begin
      errors++; $display("FAIL reset_data: wdata %h rdata %h exp 0/0", mem_wdata, rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lw_basic();
    int st, nv; bit stb, we, er, ee, to; logic [31:0] ma, mw, rd; logic [3:0] be;
    run_txn(1, 0, F3_W, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0,
            st, nv, stb, ma, mw, be, we, rd, er, ee, to);
    checks++;
    if (ma !== 32'h100 || be !== 4'b1111 || we !== 1'b0) begin
      errors++; $display("FAIL lw_req: addr %h be %b we %b exp 100/1111/0", ma, be, we);
    end
    checks++;
    if (st !== 3 || to) begin
      errors++; $display("FAIL lw_stalls: got %0d exp 3", st);
    end
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      errors++; $display("FAIL lw_rdata: got %h err %b exp deadbeef err 0", rd, er);
    end
  endtask

  task automatic test_lb_lbu();
    int st, nv; bit stb, we, er, ee, to; logic [31:0] ma, mw, rd; logic [3:0] be;
    run_txn(1, 0, F3_B, 32'h103, 32'h0, 32'h80112233, 0, 0, 0,
            st, nv, stb, ma, mw, be, we, rd, er, ee, to);
    checks++;
    if (rd !== 32'hFFFFFF80 || be !== 4'b1000) begin
      errors++; $display("FAIL lb_sext: got %h be %b exp ffffff80 be 1000", rd, be);
    end
    run_txn(1, 0, F3_BU, 32'h103, 32'h0, 32'h80112233, 1, 2, 0,
            st, nv, stb, ma, mw, be, we, rd, er, ee, to);
    checks++;
    if (rd !== 32'h00000080 || st !== 6) begin
      errors++; $display("FAIL lbu_zext: got %h stalls %0d exp 00000080 stalls 6", rd, st);
    end
  endtask

  task automatic test_sh_wait();
    int st, nv; bit stb, we, er, ee, to; logic [31:0] ma, mw, rd; logic [3:0] be;
    run_txn(0, 1, F3_H, 32'h202, 32'h0000ABCD, 32'h0, 3, 0, 0,
            st, nv, stb, ma, mw, be, we, rd, er, ee, to);
    checks++;
    if (be !== 4'b1100 || mw !== 32'hABCDABCD || ma !== 32'h200 || we !== 1'b1) begin
      errors++; $display("FAIL sh_lanes: be %b wdata %h addr %h we %b exp 1100/abcdabcd/200/1",
                         be, mw, ma, we);
    end
    checks++;
    if (st !== 5 || nv !== 4 || !stb) begin
      errors++; $display("FAIL sh_hold: stalls %0d valids %0d stable %b exp 5/4/1", st, nv, stb);
    end
    checks++;
    if (rd !== 32'h0 || er !== 1'b0 || ee) begin
      errors++; $display("FAIL sh_done: rdata %h err %b exp 0/0", rd, er);
    end
  endtask

  task automatic test_faults();
    int st, nv; bit stb, we, er, ee, to; logic [31:0] ma, mw, rd; logic [3:0] be;
    run_txn(1, 0, F3_W, 32'h101, 32'h0, 32'h12345678, 0, 0, 0,
            st, nv, stb, ma, mw, be, we, rd, er, ee, to);
    checks++;
    if (st !== 1 || nv !== 0 || er !== 1'b1 || rd !== 32'h0 || ee) begin
      errors++; $display("FAIL fault_misalign: stalls %0d valids %0d err %b rdata %h exp 1/0/1/0",
                         st, nv, er, rd);
    end
    run_txn(1, 1, F3_W, 32'h100, 32'h55, 32'h12345678, 0, 0, 0,
            st, nv, stb, ma, mw, be, we, rd, er, ee, to);
    checks++;
    if (st !== 1 || nv !== 0 || er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL fault_both: stalls %0d valids %0d err %b rdata %h exp 1/0/1/0",
                         st, nv, er, rd);
    end
    run_txn(0, 1, F3_BU, 32'h100, 32'h55, 32'h0, 0, 0, 0,
            st, nv, stb, ma, mw, be, we, rd, er, ee, to);
    checks++;
    if (st !== 1 || nv !== 0 || er !== 1'b1) begin
      errors++; $display("FAIL fault_f3: stalls %0d valids %0d err %b exp 1/0/1", st, nv, er);
    end
  endtask

  task automatic test_timeout();
    int st, nv; bit stb, we, er, ee, to; logic [31:0] ma, mw, rd; logic [3:0] be;
    run_txn(1, 0, F3_W, 32'h400, 32'h0, 32'h0, 0, 0, 1,
            st, nv, stb, ma, mw, be, we, rd, er, ee, to);
    checks++;
    if (st !== 16 || er !== 1'b1 || rd !== 32'h0 || ee || to) begin
      errors++; $display("FAIL timeout_resp: stalls %0d err %b rdata %h exp 16/1/0", st, er, rd);
    end
    run_txn(0, 1, F3_W, 32'h404, 32'h1, 32'h0, 99, 0, 0,
            st, nv, stb, ma, mw, be, we, rd, er, ee, to);
    checks++;
    if (st !== 16 || nv !== 15 || er !== 1'b1 || to) begin
      errors++; $display("FAIL timeout_req: stalls %0d valids %0d err %b exp 16/15/1", st, nv, er);
    end
  endtask

  task automatic test_reset_mid();
    int st, nv; bit stb, we, er, ee, to; logic [31:0] ma, mw, rd; logic [3:0] be;
    // reset while the request is pending
    @(posedge clk); #1;
    memread = 1'b1; funct3 = F3_W; addr = 32'h300; mem_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mem_valid !== 1'b1) begin
      errors++; $display("FAIL mid_req_valid: got %b exp 1", mem_valid);
    end
    #2; rst_n = 1'b0; memread = 1'b0;
    #1;
    checks++;
    if (mem_valid !== 1'b0 || stall !== 1'b0 || mem_addr !== 32'h0 || mem_be !== 4'h0) begin
      errors++; $display("FAIL mid_req_reset: valid %b stall %b addr %h be %b exp 0/0/0/0",
                         mem_valid, stall, mem_addr, mem_be);
    end
    @(negedge clk); rst_n = 1'b1;
    // reset while waiting for the read response
    @(posedge clk); #1;
    memread = 1'b1; funct3 = F3_W; addr = 32'h308; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    #2; rst_n = 1'b0; memread = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rdata !== 32'h0 || stall !== 1'b0 || err !== 1'b0 || mem_valid !== 1'b0) begin
      errors++; $display("FAIL mid_late_rvalid: rdata %h stall %b err %b valid %b exp 0/0/0/0",
                         rdata, stall, err, mem_valid);
    end
    mem_rvalid = 1'b0;
    run_txn(1, 0, F3_W, 32'h308, 32'h0, 32'h13579BDF, 0, 0, 0,
            st, nv, stb, ma, mw, be, we, rd, er, ee, to);
    checks++;
    if (rd !== 32'h13579BDF || st !== 3 || er !== 1'b0) begin
      errors++; $display("FAIL mid_recover: rdata %h stalls %0d err %b exp 13579bdf/3/0", rd, st, er);
    end
  endtask

  task automatic test_random();
    int st, nv; bit stb, we, er, ee, to; logic [31:0] ma, mw, rd; logic [3:0] be;
    bit r_rd, r_wr, f;
    int f3, sel, rdy, rvd, exp_st;
    logic [31:0] a, wd, word, exp_rd;
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      r_rd = (sel <= 5);
      r_wr = (sel == 0) || (sel > 5);
      f3 = $urandom_range(0, 7);
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      wd = $urandom; word = $urandom;
      rdy = $urandom_range(0, 3); rvd = $urandom_range(0, 3);
      run_txn(r_rd, r_wr, 3'(f3), a, wd, word, rdy, rvd, 0,
              st, nv, stb, ma, mw, be, we, rd, er, ee, to);
      f = m_fault(r_rd, r_wr, f3, a);
      if (f) exp_st = 1;
      else if (r_wr) exp_st = 2 + rdy;
      else exp_st = 3 + rdy + rvd;
      exp_rd = (f || r_wr) ? 32'h0 : m_load(f3, a, word);
      checks++;
      if (st !== exp_st || er !== f || ee || to) begin
        errors++; $display("FAIL rnd_flow[%0d]: stalls %0d err %b exp %0d/%b", n, st, er, exp_st, f);
      end
      checks++;
      if (rd !== exp_rd) begin
        errors++; $display("FAIL rnd_rdata[%0d]: got %h exp %h", n, rd, exp_rd);
      end
      if (!f) begin
        checks++;
        if (ma !== (a & 32'hFFFF_FFFC) || be !== m_be(f3, a) || we !== r_wr || !stb) begin
          errors++; $display("FAIL rnd_req[%0d]: addr %h be %b we %b stable %b exp %h/%b/%b/1",
                             n, ma, be, we, stb, a & 32'hFFFF_FFFC, m_be(f3, a), r_wr);
        end
        if (r_wr) begin
          checks++;
          if (mw !== m_wdata(f3, wd)) begin
            errors++; $display("FAIL rnd_wdata[%0d]: got %h exp %h", n, mw, m_wdata(f3, wd));
          end
        end
      end else begin
        checks++;
        if (nv !== 0) begin
          errors++; $display("FAIL rnd_fault_bus[%0d]: valids %0d exp 0", n, nv);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw_basic();
    test_lb_lbu();
    test_sh_wait();
    test_faults();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
